// File: rtl/demux_lane_collector.sv
// Collects demuxed serial bits into per-lane words, parks completed words in
// per-lane holding registers and drains them round-robin on a valid/ready port.
module demux_lane_collector #(
    parameter int unsigned WORD_W    = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_valid,
    output logic              bit_ready,
    input  logic [1:0]        lane_sel,
    input  logic [3:0]        lane_bits,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [WORD_W-1:0] word_data,
    output logic [1:0]        word_lane,
    output logic              protocol_err
);

    localparam int unsigned     CntW    = (WORD_W > 2) ? $clog2(WORD_W) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WORD_W - 1);

    logic [WORD_W-1:0] sr_q   [4];
    logic [WORD_W-1:0] sr_d   [4];
    logic [CntW-1:0]   cnt_q  [4];
    logic [CntW-1:0]   cnt_d  [4];
    logic [WORD_W-1:0] hold_q [4];
    logic [WORD_W-1:0] hold_d [4];
    logic [3:0]        hold_v_q, hold_v_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic              word_valid_q, word_valid_d;
    logic [WORD_W-1:0] word_data_q, word_data_d;
    logic [1:0]        word_lane_q, word_lane_d;
    logic              protocol_err_q, protocol_err_d;

    logic              sel_bit;
    logic              sel_last;
    logic              bit_acc;
    logic [WORD_W-1:0] shifted;
    logic [3:0]        sel_onehot;
    logic              out_load;
    logic              pick_found;
    logic [1:0]        pick_lane;
    logic [1:0]        scan_idx;

    // A lane stalls only when its hold is still occupied and this bit would complete a word.
    always_comb begin
        sel_bit    = lane_bits[lane_sel];
        sel_last   = (cnt_q[lane_sel] == CntLast);
        bit_ready  = !(hold_v_q[lane_sel] && sel_last);
        bit_acc    = bit_valid && bit_ready;
        sel_onehot = 4'b0001 << lane_sel;
        if (MSB_FIRST) begin
            shifted = {sr_q[lane_sel][WORD_W-2:0], sel_bit};
        end else begin
            shifted = {sel_bit, sr_q[lane_sel][WORD_W-1:1]};
        end
    end

    // Round-robin scan starting at rr_ptr over the registered hold flags.
    always_comb begin
        out_load   = !word_valid_q || word_ready;
        pick_found = 1'b0;
        pick_lane  = rr_ptr_q;
        scan_idx   = rr_ptr_q;
        for (int i = 0; i < 4; i++) begin
            scan_idx = rr_ptr_q + 2'(i);
            if (!pick_found && hold_v_q[scan_idx]) begin
                pick_found = 1'b1;
                pick_lane  = scan_idx;
            end
        end
    end

    always_comb begin
        sr_d           = sr_q;
        cnt_d          = cnt_q;
        hold_d         = hold_q;
        hold_v_d       = hold_v_q;
        rr_ptr_d       = rr_ptr_q;
        word_valid_d   = word_valid_q;
        word_data_d    = word_data_q;
        word_lane_d    = word_lane_q;
        protocol_err_d = protocol_err_q;

        if (out_load) begin
            if (pick_found) begin
                word_valid_d        = 1'b1;
                word_data_d         = hold_q[pick_lane];
                word_lane_d         = pick_lane;
                hold_v_d[pick_lane] = 1'b0;
                rr_ptr_d            = pick_lane + 2'd1;
            end else begin
                word_valid_d = 1'b0;
            end
        end

        // A completing lane never has its hold cleared this cycle, since bit_ready requires it empty.
        if (bit_acc) begin
            if ((lane_bits & ~sel_onehot) != 4'b0000) begin
                protocol_err_d = 1'b1;
            end
            sr_d[lane_sel] = shifted;
            if (sel_last) begin
                hold_d[lane_sel]   = shifted;
                hold_v_d[lane_sel] = 1'b1;
                cnt_d[lane_sel]    = '0;
            end else begin
                cnt_d[lane_sel] = cnt_q[lane_sel] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                sr_q[i]   <= '0;
                cnt_q[i]  <= '0;
                hold_q[i] <= '0;
            end
            hold_v_q       <= '0;
            rr_ptr_q       <= '0;
            word_valid_q   <= 1'b0;
            word_data_q    <= '0;
            word_lane_q    <= '0;
            protocol_err_q <= 1'b0;
        end else begin
            sr_q           <= sr_d;
            cnt_q          <= cnt_d;
            hold_q         <= hold_d;
            hold_v_q       <= hold_v_d;
            rr_ptr_q       <= rr_ptr_d;
            word_valid_q   <= word_valid_d;
            word_data_q    <= word_data_d;
            word_lane_q    <= word_lane_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    assign word_valid   = word_valid_q;
    assign word_data    = word_data_q;
    assign word_lane    = word_lane_q;
    assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_demux_lane_collector.sv
// Self-checking bench: two collectors (MSB-first and LSB-first) share one stimulus stream
// and are compared every cycle against a word-level reference model plus directed checks.
module tb_demux_lane_collector;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         bit_valid;
    logic [1:0]   lane_sel;
    logic [3:0]   lane_bits;
    logic         word_ready;

    logic         ready_m, valid_m, perr_m;
    logic [W-1:0] data_m;
    logic [1:0]   lane_m;
    logic         ready_l, valid_l, perr_l;
    logic [W-1:0] data_l;
    logic [1:0]   lane_l;

    demux_lane_collector #(.WORD_W(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_ready(ready_m),
        .lane_sel(lane_sel), .lane_bits(lane_bits), .word_valid(valid_m),
        .word_ready(word_ready), .word_data(data_m), .word_lane(lane_m),
        .protocol_err(perr_m)
    );

    demux_lane_collector #(.WORD_W(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_ready(ready_l),
        .lane_sel(lane_sel), .lane_bits(lane_bits), .word_valid(valid_l),
        .word_ready(word_ready), .word_data(data_l), .word_lane(lane_l),
        .protocol_err(perr_l)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: bits gathered in arrival order (first bit = MSB); words as values.
    int           m_cnt  [4];
    logic [W-1:0] m_acc  [4];
    logic         m_hv   [4];
    logic [W-1:0] m_hold [4];
    logic         m_ov;
    logic [W-1:0] m_od;
    int           m_ol;
    int           m_rr;
    logic         m_perr;
    logic         m_last_acc;
    int           hs_lanes[$];
    logic [W-1:0] hs_data[$];

    function automatic logic [W-1:0] rev(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[W-1-i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0; m_acc[i] = '0; m_hv[i] = 1'b0; m_hold[i] = '0;
        end
        m_ov = 1'b0; m_od = '0; m_ol = 0; m_rr = 0; m_perr = 1'b0; m_last_acc = 1'b0;
    endtask

    task automatic cycle();
        logic       mr, acc, found;
        int         l;
        logic [3:0] oh;
        @(negedge clk);
        mr = !(m_hv[lane_sel] && m_cnt[lane_sel] == W - 1);
        check("bit_ready_m", 32'(ready_m), 32'(mr));
        check("bit_ready_l", 32'(ready_l), 32'(mr));
        check("word_valid_m", 32'(valid_m), 32'(m_ov));
        check("word_valid_l", 32'(valid_l), 32'(m_ov));
        check("word_data_m", 32'(data_m), 32'(m_od));
        check("word_data_l", 32'(data_l), 32'(rev(m_od)));
        check("word_lane_m", 32'(lane_m), 32'(m_ol));
        check("word_lane_l", 32'(lane_l), 32'(m_ol));
        check("protocol_err", 32'(perr_m), 32'(m_perr));
        if (m_ov && word_ready) begin
            hs_lanes.push_back(m_ol);
            hs_data.push_back(m_od);
        end
        @(posedge clk);
        acc = bit_valid && mr;
        if (!m_ov || word_ready) begin
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                l = (m_rr + k) % 4;
                if (!found && m_hv[l]) begin
                    found = 1'b1;
                    m_ov = 1'b1; m_od = m_hold[l]; m_ol = l; m_hv[l] = 1'b0;
                    m_rr = (l + 1) % 4;
                end
            end
            if (!found) m_ov = 1'b0;
        end
        if (acc) begin
            l  = int'(lane_sel);
            oh = 4'b0001 << l;
            if ((lane_bits & ~oh) != 4'b0000) m_perr = 1'b1;
            m_acc[l] = {m_acc[l][W-2:0], lane_bits[l]};
            m_cnt[l]++;
            if (m_cnt[l] == W) begin
                m_hold[l] = m_acc[l]; m_hv[l] = 1'b1; m_cnt[l] = 0;
            end
        end
        m_last_acc = acc;
        #1;
    endtask

    task automatic idle(input int n);
        bit_valid = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic send_bit(input int l, input logic b);
        int n = 0;
        lane_sel  = 2'(l);
        lane_bits = 4'(b) << l;
        bit_valid = 1'b1;
        do begin
            cycle();
            n++;
        end while (!m_last_acc && n < 64);
        if (!m_last_acc) check("bit_accept_timeout", 32'd0, 32'd1);
        bit_valid = 1'b0;
    endtask

    // Bits are presented in transmission order, leftmost (w[W-1]) first.
    task automatic send_word(input int l, input logic [W-1:0] w);
        for (int k = W - 1; k >= 0; k--) send_bit(l, w[k]);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, 32'(valid_m | valid_l), 32'd0);
        check({tag, "_data_m"}, 32'(data_m), 32'd0);
        check({tag, "_data_l"}, 32'(data_l), 32'd0);
        check({tag, "_lane"}, 32'(lane_m | lane_l), 32'd0);
        check({tag, "_perr"}, 32'(perr_m | perr_l), 32'd0);
        check({tag, "_ready"}, 32'(ready_m & ready_l), 32'd1);
    endtask

    // Called just after a posedge; reset is asserted and released between edges.
    task automatic rst_pulse(input string tag);
        rst_n = 1'b0;
        #2;
        model_reset();
        check_reset_state(tag);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (tests %0d)", tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] w3;
        rst_n = 1'b0; bit_valid = 1'b0; lane_sel = 2'd0; lane_bits = 4'd0; word_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        #3 rst_n = 1'b1;

        // Lane 2, bits 1,0,1,0,0,1,0,1: word appears two cycles after the last bit.
        send_word(2, 8'hA5);
        cycle();
        check("t2_valid", 32'(valid_m), 32'd1);
        check("t2_data_m", 32'(data_m), 32'h A5);
        check("t2_lane", 32'(lane_m), 32'd2);
        check("t3_data_l_pal", 32'(data_l), 32'h A5);
        idle(2);

        // Bits 1,1,0,0,0,0,0,0 on lane 0.
        send_word(0, 8'hC0);
        cycle();
        check("t3_data_l", 32'(data_l), 32'h03);
        check("t3_data_m", 32'(data_m), 32'h C0);
        check("t3_lane", 32'(lane_l), 32'd0);
        idle(2);

        // Round-robin order between lanes 0 and 3 for two pointer positions.
        rst_pulse("t4_rst");
        word_ready = 1'b0;
        send_word(3, 8'h11);
        send_word(3, 8'h22);
        send_word(0, 8'h33);
        hs_lanes.delete(); hs_data.delete();
        word_ready = 1'b1;
        idle(6);
        check("t4a_count", 32'(hs_lanes.size()), 32'd3);
        if (hs_lanes.size() == 3) begin
            check("t4a_first", 32'(hs_lanes[0]), 32'd3);
            check("t4a_second", 32'(hs_lanes[1]), 32'd0);
            check("t4a_third", 32'(hs_lanes[2]), 32'd3);
        end
        word_ready = 1'b0;
        send_word(0, 8'h44);
        send_word(0, 8'h55);
        send_word(3, 8'h66);
        hs_lanes.delete(); hs_data.delete();
        word_ready = 1'b1;
        idle(6);
        check("t4b_count", 32'(hs_lanes.size()), 32'd3);
        if (hs_lanes.size() == 3) begin
            check("t4b_first", 32'(hs_lanes[0]), 32'd0);
            check("t4b_second", 32'(hs_lanes[1]), 32'd3);
            check("t4b_third", 32'(hs_lanes[2]), 32'd0);
            check("t4b_second_data", 32'(hs_data[1]), 32'h66);
        end

        // Backpressure on lane 1 only.
        hs_lanes.delete(); hs_data.delete();
        word_ready = 1'b0;
        w3 = 8'h9B;
        send_word(1, 8'h5A);
        send_word(1, 8'hE7);
        for (int k = W - 1; k >= 1; k--) send_bit(1, w3[k]);
        lane_sel = 2'd1;
        #1 check("t5_ready_lane1", 32'(ready_m), 32'd0);
        lane_sel = 2'd0;
        #1 check("t5_ready_lane0", 32'(ready_m), 32'd1);
        idle(4);
        word_ready = 1'b1;
        send_bit(1, w3[0]);
        idle(6);
        check("t5_count", 32'(hs_data.size()), 32'd3);
        if (hs_data.size() == 3) begin
            check("t5_w1", 32'(hs_data[0]), 32'h5A);
            check("t5_w2", 32'(hs_data[1]), 32'h E7);
            check("t5_w3", 32'(hs_data[2]), 32'h9B);
        end

        // Randomized traffic, mostly well-formed one-hot lane bits.
        for (int n = 0; n < 1500; n++) begin
            bit_valid  = ($urandom_range(0, 2) != 0);
            lane_sel   = 2'($urandom_range(0, 3));
            lane_bits  = 4'($urandom_range(0, 1)) << lane_sel;
            if ($urandom_range(0, 19) == 0) lane_bits = 4'($urandom_range(0, 15));
            word_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        word_ready = 1'b1;
        idle(12);

        // Sticky protocol error, then reset discards everything.
        rst_pulse("t6_rst0");
        lane_sel = 2'd1; lane_bits = 4'b0110; bit_valid = 1'b1;
        cycle();
        bit_valid = 1'b0;
        check("t6_perr_set", 32'(perr_m), 32'd1);
        for (int k = 0; k < 5; k++) send_bit(0, 1'(k & 1));
        idle(3);
        check("t6_perr_sticky", 32'(perr_l), 32'd1);
        rst_pulse("t6_rst1");
        hs_lanes.delete(); hs_data.delete();
        send_word(0, 8'h3C);
        idle(5);
        check("t6_count", 32'(hs_data.size()), 32'd1);
        if (hs_data.size() == 1) check("t6_word", 32'(hs_data[0]), 32'h3C);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
